decode_cycle: RTL and testbench

DECODE_CYCLE -- requirements
Module: decode_cycle

---
 rtl/decode_cycle_pkg.sv | 78 +++++++
 rtl/decode_cycle_regfile.sv | 36 +++
 rtl/decode_cycle.sv | 119 +++++++++++
 tb/tb_decode_cycle.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_cycle_pkg.sv
// Shared encodings for the decode, execute and writeback stages of the pipeline.
// Also holds the decode-to-execute register payload and the decode helper functions.
package decode_cycle_pkg;

    typedef enum logic [6:0] {
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_RTYPE = 7'b0110011,
        OP_IALU  = 7'b0010011,
        OP_BEQ   = 7'b1100011,
        OP_JAL   = 7'b1101111
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        result_src_t result_src;
        alu_ctrl_t   alu_ctrl;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } de_reg_t;

    // funct7[5] only selects subtract for register-register ops; for I-ALU it is immediate data.
    function automatic alu_ctrl_t alu_decode(input logic [2:0] funct3, input logic funct7_b5,
                                             input logic is_rtype);
        case (funct3)
            3'b000:  return (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] imm_extend(input logic [31:7] ins, input imm_src_t src);
        case (src)
            IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J:   return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return {{20{ins[31]}}, ins[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/decode_cycle_regfile.sv
// 32x32 register file: two combinational read ports with write-through, one write port.
// x0 is hardwired to zero and reset clears every entry.
module Register_File (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0][31:0] regs;
    logic              wr_en;

    assign wr_en = we && (wa != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // A read of the register being written this cycle sees the new value.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != 5'd0) rd1 = (wr_en && wa == ra1) ? wd : regs[ra1];
        if (ra2 != 5'd0) rd2 = (wr_en && wa == ra2) ? wd : regs[ra2];
    end

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: control decode, immediate extension, register read and the decode/execute
// pipeline register. Flush and reset both load a bubble; reset also masks outputs combinationally.
module decode_cycle
    import decode_cycle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  RdE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E
);

    ctrl_t       ctrl_d;
    imm_src_t    imm_src_d;
    logic [31:0] rd1_d, rd2_d;
    de_reg_t     de_d, de_q, de_e;

    always_comb begin
        ctrl_d    = '0;
        imm_src_d = IMM_I;
        case (InstrD[6:0])
            OP_LOAD: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.result_src = RES_MEM;
            end
            OP_STORE: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                imm_src_d        = IMM_S;
            end
            OP_BEQ: begin
                ctrl_d.branch   = 1'b1;
                ctrl_d.alu_ctrl = ALU_SUB;
                imm_src_d       = IMM_B;
            end
            OP_JAL: begin
                ctrl_d.jump       = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = RES_PC4;
                imm_src_d         = IMM_J;
            end
            OP_RTYPE, OP_IALU: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = (InstrD[6:0] == OP_IALU);
                ctrl_d.alu_ctrl  = alu_decode(InstrD[14:12], InstrD[30], InstrD[6:0] == OP_RTYPE);
            end
            default: ;
        endcase
    end

    Register_File u_rf (
        .clk (clk),
        .rst (rst),
        .we  (RegWriteW),
        .wa  (RDW),
        .wd  (ResultW),
        .ra1 (InstrD[19:15]),
        .ra2 (InstrD[24:20]),
        .rd1 (rd1_d),
        .rd2 (rd2_d)
    );

    always_comb begin
        de_d          = '0;
        de_d.ctrl     = ctrl_d;
        de_d.rd1      = rd1_d;
        de_d.rd2      = rd2_d;
        de_d.imm      = imm_extend(InstrD[31:7], imm_src_d);
        de_d.pc       = PCD;
        de_d.pc_plus4 = PCPlus4D;
        de_d.rd       = InstrD[11:7];
        de_d.rs1      = InstrD[19:15];
        de_d.rs2      = InstrD[24:20];
    end

    always_ff @(posedge clk) begin
        if (rst || FlushE) de_q <= '0;
        else               de_q <= de_d;
    end

    assign de_e = rst ? '0 : de_q;

    assign RegWriteE   = de_e.ctrl.reg_write;
    assign MemWriteE   = de_e.ctrl.mem_write;
    assign JumpE       = de_e.ctrl.jump;
    assign BranchE     = de_e.ctrl.branch;
    assign ALUSrcE     = de_e.ctrl.alu_src;
    assign ResultSrcE  = de_e.ctrl.result_src;
    assign ALUControlE = de_e.ctrl.alu_ctrl;
    assign RD1E        = de_e.rd1;
    assign RD2E        = de_e.rd2;
    assign ImmExtE     = de_e.imm;
    assign PCE         = de_e.pc;
    assign PCPlus4E    = de_e.pc_plus4;
    assign RdE         = de_e.rd;
    assign Rs1E        = de_e.rs1;
    assign Rs2E        = de_e.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: ISA-level model of the decode stage checked every negedge,
// plus hand-computed literal checks on the directed instruction sequence.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RdE, Rs1E, Rs2E;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic chk = 1'b0;

    // model state: architectural registers and the expected execute-stage view
    logic [31:0] rf_m [32];
    logic        e_rw, e_mw, e_j, e_b, e_as, e_immv;
    logic [1:0]  e_res;
    logic [2:0]  e_alu;
    logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pc4;
    logic [4:0]  e_rd, e_rs1, e_rs2;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m(input logic [31:0] v);
        return rst ? 32'd0 : v;
    endfunction

    always @(negedge clk) begin
        if (chk) begin
            check("RegWriteE",   32'(RegWriteE),   m(32'(e_rw)));
            check("MemWriteE",   32'(MemWriteE),   m(32'(e_mw)));
            check("JumpE",       32'(JumpE),       m(32'(e_j)));
            check("BranchE",     32'(BranchE),     m(32'(e_b)));
            check("ALUSrcE",     32'(ALUSrcE),     m(32'(e_as)));
            check("ResultSrcE",  32'(ResultSrcE),  m(32'(e_res)));
            check("ALUControlE", 32'(ALUControlE), m(32'(e_alu)));
            check("RD1E",        RD1E,             m(e_rd1));
            check("RD2E",        RD2E,             m(e_rd2));
            if (e_immv || rst) check("ImmExtE", ImmExtE, m(e_imm));
            check("PCE",         PCE,              m(e_pc));
            check("PCPlus4E",    PCPlus4E,         m(e_pc4));
            check("RdE",         32'(RdE),         m(32'(e_rd)));
            check("Rs1E",        32'(Rs1E),        m(32'(e_rs1)));
            check("Rs2E",        32'(Rs2E),        m(32'(e_rs2)));
        end
    end

    // Predict the post-edge state from the current inputs, then advance one clock.
    task automatic cycle();
        logic [31:0] i = InstrD;
        logic [31:0] rf_n [32];
        logic rw = 0, mw = 0, j = 0, b = 0, as = 0, immv = 1;
        logic [1:0] res = 0;
        logic [2:0] alu = 0;
        logic [31:0] imm = 0;
        rf_n = rf_m;
        if (rst) foreach (rf_n[k]) rf_n[k] = 32'd0;
        else if (RegWriteW && RDW != 0) rf_n[RDW] = ResultW;
        case (i[6:0])
            7'b0000011: begin rw = 1; as = 1; res = 2'b01; imm = 32'($signed(i[31:20])); end
            7'b0100011: begin mw = 1; as = 1; imm = 32'($signed({i[31:25], i[11:7]})); end
            7'b1100011: begin b = 1; alu = 3'b001;
                              imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
            7'b1101111: begin j = 1; rw = 1; res = 2'b10;
                              imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
            7'b0110011, 7'b0010011: begin
                rw = 1;
                as = (i[6:0] == 7'b0010011);
                if (as) imm = 32'($signed(i[31:20])); else immv = 0;
                case (i[14:12])
                    3'b000: alu = (!as && i[30]) ? 3'b001 : 3'b000;
                    3'b010: alu = 3'b101;
                    3'b110: alu = 3'b011;
                    3'b111: alu = 3'b010;
                    default: alu = 3'b000;
                endcase
            end
            default: immv = 0;
        endcase
        @(posedge clk);
        #1;
        if (rst || FlushE) begin
            {e_rw, e_mw, e_j, e_b, e_as, e_res, e_alu} = '0;
            {e_rd1, e_rd2, e_imm, e_pc, e_pc4, e_rd, e_rs1, e_rs2} = '0;
            e_immv = 1;
        end else begin
            {e_rw, e_mw, e_j, e_b, e_as, e_res, e_alu, e_imm, e_immv} =
                {rw, mw, j, b, as, res, alu, imm, immv};
            e_rd1 = (i[19:15] == 0) ? 32'd0 : rf_n[i[19:15]];
            e_rd2 = (i[24:20] == 0) ? 32'd0 : rf_n[i[24:20]];
            {e_pc, e_pc4, e_rd, e_rs1, e_rs2} = {PCD, PCPlus4D, i[11:7], i[19:15], i[24:20]};
        end
        rf_m = rf_n;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] val);
        RegWriteW = we; RDW = rd; ResultW = val;
    endtask

    initial begin
        foreach (rf_m[k]) rf_m[k] = 32'd0;
        rst = 1; FlushE = 0;
        wb(0, 0, 0);
        issue(32'h0, 32'h0);
        cycle();
        cycle();
        rst = 0;
        chk = 1;
        check("reset_RegWriteE", 32'(RegWriteE), 0);
        check("reset_RD1E", RD1E, 0);

        issue(32'h00500093, 32'h100);                 // addi x1,x0,5
        cycle();
        check("addi_RegWriteE", 32'(RegWriteE), 1);
        check("addi_ALUSrcE", 32'(ALUSrcE), 1);
        check("addi_ALUControlE", 32'(ALUControlE), 0);
        check("addi_ImmExtE", ImmExtE, 5);
        check("addi_RdE", 32'(RdE), 1);
        check("addi_RD1E", RD1E, 0);

        wb(1, 2, 32'hDEADBEEF);
        issue(32'h00010133, 32'h104);                 // add x2,x2,x0 with write-through
        cycle();
        check("bypass_RD1E", RD1E, 32'hDEADBEEF);
        wb(0, 0, 0);
        cycle();
        check("stored_RD1E", RD1E, 32'hDEADBEEF);

        wb(1, 0, 32'h1234);
        issue(32'h000001B3, 32'h108);                 // add x3,x0,x0 while writing x0
        cycle();
        check("x0_bypass_RD1E", RD1E, 0);
        wb(0, 0, 0);
        cycle();
        check("x0_read_RD1E", RD1E, 0);

        issue(32'hFE000EE3, 32'h10C);                 // beq x0,x0,-4
        cycle();
        check("beq_BranchE", 32'(BranchE), 1);
        check("beq_ALUControlE", 32'(ALUControlE), 3'b001);
        check("beq_ImmExtE", ImmExtE, 32'hFFFFFFFC);

        issue(32'h008000EF, 32'h110);                 // jal x1,8 flushed, writeback x5 still lands
        FlushE = 1;
        wb(1, 5, 32'h55);
        cycle();
        check("flush_JumpE", 32'(JumpE), 0);
        check("flush_RdE", 32'(RdE), 0);
        check("flush_PCE", PCE, 0);
        FlushE = 0;
        wb(0, 0, 0);
        cycle();
        check("jal_JumpE", 32'(JumpE), 1);
        check("jal_ResultSrcE", 32'(ResultSrcE), 2'b10);
        check("jal_ImmExtE", ImmExtE, 8);

        issue(32'h0042A303, 32'h114);                 // lw x6,4(x5)
        cycle();
        check("lw_RD1E", RD1E, 32'h55);
        check("lw_ResultSrcE", 32'(ResultSrcE), 2'b01);
        issue(32'h0020A423, 32'h118);                 // sw x2,8(x1)
        cycle();
        check("sw_MemWriteE", 32'(MemWriteE), 1);
        check("sw_ImmExtE", ImmExtE, 8);
        check("sw_RD2E", RD2E, 32'hDEADBEEF);
        issue(32'h402081B3, 32'h11C);                 // sub x3,x1,x2
        cycle();
        check("sub_ALUControlE", 32'(ALUControlE), 3'b001);
        issue(32'h0020A233, 32'h120);                 // slt x4,x1,x2
        cycle();
        issue(32'hFFF0E293, 32'h124);                 // ori x5,x1,-1
        cycle();
        check("ori_ImmExtE", ImmExtE, 32'hFFFFFFFF);
        check("ori_ALUControlE", 32'(ALUControlE), 3'b011);
        issue(32'h4000F393, 32'h128);                 // andi x7,x1,0x400 (funct7[5] set)
        cycle();
        check("andi_ALUControlE", 32'(ALUControlE), 3'b010);
        issue(32'h40008393, 32'h12C);                 // addi with imm bit 30 set stays add
        cycle();
        check("addi_hi_ALUControlE", 32'(ALUControlE), 3'b000);

        issue(32'hFFFFFFFF, 32'h130);                 // illegal opcode
        cycle();
        check("illegal_RegWriteE", 32'(RegWriteE), 0);
        check("illegal_ResultSrcE", 32'(ResultSrcE), 0);

        issue(32'h00500093, 32'h134);
        cycle();
        rst = 1;                                      // mid-stream reset beats write-back
        wb(1, 7, 32'h77);
        cycle();
        check("rst_RegWriteE", 32'(RegWriteE), 0);
        check("rst_PCPlus4E", PCPlus4E, 0);
        rst = 0;
        wb(0, 0, 0);
        issue(32'h00038433, 32'h138);                 // add x8,x7,x0
        cycle();
        check("rst_dropped_wb_RD1E", RD1E, 0);
        issue(32'h00010433, 32'h13C);                 // add x8,x2,x0: x2 cleared by reset
        cycle();
        check("rst_cleared_RD1E", RD1E, 0);
        cycle();

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
